// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared types and defaults for the multiplexed external memory bus
// controller (mem_bus_ctrl) and its round-robin arbiter (bus_arb).
//   busState_t : bus cycle phase (IDLE, ADDR, STRB, END)
//   owner_t    : which requester owns the current access (FETCH, DATA)
//   MAX_WAIT_DEFAULT : default limit on STRB cycles spent with nWait low
// ---------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        STRB = 2'd2,
        END  = 2'd3
    } busState_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    localparam int MAX_WAIT_DEFAULT = 15;

    // Width of a counter that must hold 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/bus_arb.sv
// ---------------------------------------------------------------------------
// bus_arb
// Two-way round-robin selection between instruction fetch and data access.
// Purely combinational; the controller samples it only while idle.
// Ports:
//   i_fetch_req : fetch request pending
//   i_data_req  : load/store request pending
//   i_last      : owner of the previous access
//   o_grant     : at least one request pending
//   o_owner     : selected requester
// ---------------------------------------------------------------------------
module bus_arb
    import bus_pkg::*;
(
    input  logic   i_fetch_req,
    input  logic   i_data_req,
    input  owner_t i_last,
    output logic   o_grant,
    output owner_t o_owner
);

    always_comb begin
        o_grant = i_fetch_req | i_data_req;
        o_owner = FETCH;
        if (i_fetch_req && i_data_req) begin
            // On a tie, whoever was not served last goes next.
            o_owner = (i_last == FETCH) ? DATA : FETCH;
        end else if (i_data_req) begin
            o_owner = DATA;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
// Multiplexed address/data external memory bus controller shared by an
// instruction-fetch port and a load/store port. Every bus strobe, the
// completion pulses and the read data come straight from flops.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | bus idle / turnaround; arbitrate and latch the winning request
// ADDR  | address phase: ALE high, address driven on the shared bus
// STRB  | strobe phase: nME low, nOE low (read) or write data driven;
//       | stays here while nWait is low, up to MAX_WAIT extra cycles
// END   | strobes released, Done (and BusErr on timeout) pulse
//
// Ports:
//   i_clk_sys, i_rst          : clock, async active-high reset
//   i_fetch_req, i_fetch_addr : instruction fetch request
//   i_data_req, i_data_wr, i_data_addr, i_data_wdata : load/store request
//   o_fetch_done, o_data_done : one-cycle completion pulse to the owner
//   o_bus_err                 : pulses with Done when the access timed out
//   o_rd_data                 : last read data captured from the bus
//   i_data_in                 : bus sample
//   o_addr_data_out, o_data_oe: multiplexed address/write data, pad enable
//   o_ale, o_n_me, o_n_oe, o_rnw : bus strobes
//   i_n_wait                  : active-low wait from memory
// ---------------------------------------------------------------------------
module mem_bus_ctrl
    import bus_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        i_clk_sys,
    input  logic        i_rst,
    input  logic        i_fetch_req,
    input  logic [15:0] i_fetch_addr,
    input  logic        i_data_req,
    input  logic        i_data_wr,
    input  logic [15:0] i_data_addr,
    input  logic [15:0] i_data_wdata,
    output logic        o_fetch_done,
    output logic        o_data_done,
    output logic        o_bus_err,
    output logic [15:0] o_rd_data,
    input  logic [15:0] i_data_in,
    output logic [15:0] o_addr_data_out,
    output logic        o_data_oe,
    output logic        o_ale,
    output logic        o_n_me,
    output logic        o_n_oe,
    output logic        o_rnw,
    input  logic        i_n_wait
);

    localparam int WCW = cnt_width(MAX_WAIT);

    busState_t      r_state;
    owner_t         r_last;
    owner_t         r_owner;
    logic           r_wr;
    logic [15:0]    r_wdata;
    logic [WCW-1:0] r_wait_cnt;

    logic           r_fetch_done;
    logic           r_data_done;
    logic           r_bus_err;
    logic [15:0]    r_rd_data;
    logic [15:0]    r_addr_data;
    logic           r_data_oe;
    logic           r_ale;
    logic           r_n_me;
    logic           r_n_oe;
    logic           r_rnw;

    logic           w_grant;
    owner_t         w_owner;
    logic [15:0]    w_req_addr;
    logic           w_wait_max;
    logic           w_timeout;
    logic           w_strb_exit;

    bus_arb u_arb (
        .i_fetch_req (i_fetch_req),
        .i_data_req  (i_data_req),
        .i_last      (r_last),
        .o_grant     (w_grant),
        .o_owner     (w_owner)
    );

    assign w_req_addr  = (w_owner == DATA) ? i_data_addr : i_fetch_addr;
    assign w_wait_max  = (r_wait_cnt == WCW'(MAX_WAIT));
    assign w_timeout   = ~i_n_wait & w_wait_max;
    assign w_strb_exit = i_n_wait | w_wait_max;

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_last       <= FETCH;
            r_owner      <= FETCH;
            r_wr         <= 1'b0;
            r_wdata      <= 16'h0000;
            r_wait_cnt   <= '0;
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_bus_err    <= 1'b0;
            r_rd_data    <= 16'h0000;
            r_addr_data  <= 16'h0000;
            r_data_oe    <= 1'b0;
            r_ale        <= 1'b0;
            r_n_me       <= 1'b1;
            r_n_oe       <= 1'b1;
            r_rnw        <= 1'b1;
        end else begin
            // Completion pulses last exactly one cycle (the END cycle).
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_bus_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state     <= ADDR;
                        r_owner     <= w_owner;
                        r_last      <= w_owner;
                        r_wr        <= (w_owner == DATA) & i_data_wr;
                        r_wdata     <= i_data_wdata;
                        r_addr_data <= w_req_addr;
                        r_ale       <= 1'b1;
                        r_data_oe   <= 1'b1;
                        r_n_me      <= 1'b1;
                        r_n_oe      <= 1'b1;
                        r_rnw       <= 1'b1;
                    end
                end
                ADDR: begin
                    r_state    <= STRB;
                    r_wait_cnt <= '0;
                    r_ale      <= 1'b0;
                    r_n_me     <= 1'b0;
                    if (r_wr) begin
                        r_n_oe      <= 1'b1;
                        r_rnw       <= 1'b0;
                        r_data_oe   <= 1'b1;
                        r_addr_data <= r_wdata;
                    end else begin
                        // Release the pads before the memory drives them.
                        r_n_oe    <= 1'b0;
                        r_rnw     <= 1'b1;
                        r_data_oe <= 1'b0;
                    end
                end
                STRB: begin
                    if (w_strb_exit) begin
                        if (i_n_wait && !r_wr) begin
                            r_rd_data <= i_data_in;
                        end
                        r_state      <= END;
                        r_n_me       <= 1'b1;
                        r_n_oe       <= 1'b1;
                        r_rnw        <= 1'b1;
                        r_data_oe    <= 1'b0;
                        r_fetch_done <= (r_owner == FETCH);
                        r_data_done  <= (r_owner == DATA);
                        r_bus_err    <= w_timeout;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end
                end
                END: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_fetch_done    = r_fetch_done;
    assign o_data_done     = r_data_done;
    assign o_bus_err       = r_bus_err;
    assign o_rd_data       = r_rd_data;
    assign o_addr_data_out = r_addr_data;
    assign o_data_oe       = r_data_oe;
    assign o_ale           = r_ale;
    assign o_n_me          = r_n_me;
    assign o_n_oe          = r_n_oe;
    assign o_rnw           = r_rnw;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = 16'h0000;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [15:0] data_addr = 16'h0000;
    logic [15:0] data_wdata = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic        n_wait = 1'b1;

    logic        fetch_done;
    logic        data_done;
    logic        bus_err;
    logic [15:0] rd_data;
    logic [15:0] addr_data;
    logic        data_oe;
    logic        ale;
    logic        n_me;
    logic        n_oe;
    logic        rnw;

    mem_bus_ctrl #(.MAX_WAIT(15)) dut (
        .i_clk_sys       (clk_sys),
        .i_rst           (rst),
        .i_fetch_req     (fetch_req),
        .i_fetch_addr    (fetch_addr),
        .i_data_req      (data_req),
        .i_data_wr       (data_wr),
        .i_data_addr     (data_addr),
        .i_data_wdata    (data_wdata),
        .o_fetch_done    (fetch_done),
        .o_data_done     (data_done),
        .o_bus_err       (bus_err),
        .o_rd_data       (rd_data),
        .i_data_in       (data_in),
        .o_addr_data_out (addr_data),
        .o_data_oe       (data_oe),
        .o_ale           (ale),
        .o_n_me          (n_me),
        .o_n_oe          (n_oe),
        .o_rnw           (rnw),
        .i_n_wait        (n_wait)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic        is_data;
        logic        err;
        logic [15:0] rd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Queue an expected completion; the request is sampled on the next edge.
    task automatic issue(input logic is_data, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic err, input logic [15:0] rd,
                         input int waits);
        exp_t e;
        @(posedge clk_sys);
        #1;
        if (is_data) begin
            data_req   = 1'b1;
            data_wr    = wr;
            data_addr  = addr;
            data_wdata = wdata;
        end else begin
            fetch_req  = 1'b1;
            fetch_addr = addr;
        end
        e.is_data = is_data;
        e.err     = err;
        e.rd      = rd;
        e.cyc     = cyc + 3 + waits;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk_sys);
        chk("responses_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor / scoreboard
    always @(negedge clk_sys) begin
        if (!rst) begin
            if (ale) chk("ale_with_nme_low", 32'(n_me), 32'd1);
            if (data_oe) chk("oe_with_noe_low", 32'(n_oe), 32'd1);
            if (bus_err) chk("buserr_without_done", 32'(fetch_done | data_done), 32'd1);
            if (fetch_done || data_done) begin
                chk("both_done", 32'(fetch_done & data_done), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(fetch_done | data_done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_owner_is_data", 32'(data_done), 32'(e.is_data));
                    chk("done_bus_err", 32'(bus_err), 32'(e.err));
                    chk("done_rd_data", 32'(rd_data), 32'(e.rd));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        exp_t e;

        // Reset values
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_ale", 32'(ale), 32'd0);
        chk("rst_n_me", 32'(n_me), 32'd1);
        chk("rst_n_oe", 32'(n_oe), 32'd1);
        chk("rst_rnw", 32'(rnw), 32'd1);
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        chk("rst_addr_data", 32'(addr_data), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_fetch_done", 32'(fetch_done), 32'd0);
        chk("rst_data_done", 32'(data_done), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk_sys);
        #1 rst = 1'b0;

        // Read, no wait, request dropped after it has been taken
        data_in = 16'hBEEF;
        issue(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 16'hBEEF, 0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("rd_addr_ale", 32'(ale), 32'd1);
        chk("rd_addr_bus", 32'(addr_data), 32'h1234);
        chk("rd_addr_oe", 32'(data_oe), 32'd1);
        chk("rd_addr_n_me", 32'(n_me), 32'd1);
        data_req = 1'b0;
        @(negedge clk_sys);
        chk("rd_strb_ale", 32'(ale), 32'd0);
        chk("rd_strb_n_me", 32'(n_me), 32'd0);
        chk("rd_strb_n_oe", 32'(n_oe), 32'd0);
        chk("rd_strb_rnw", 32'(rnw), 32'd1);
        chk("rd_strb_oe", 32'(data_oe), 32'd0);
        drain(20);

        // Write; write data changed after capture must not reach the bus
        issue(1'b1, 1'b1, 16'h0040, 16'hA5A5, 1'b0, 16'hBEEF, 0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("wr_addr_bus", 32'(addr_data), 32'h0040);
        data_req   = 1'b0;
        data_wdata = 16'h0000;
        @(negedge clk_sys);
        chk("wr_strb_rnw", 32'(rnw), 32'd0);
        chk("wr_strb_oe", 32'(data_oe), 32'd1);
        chk("wr_strb_bus", 32'(addr_data), 32'hA5A5);
        chk("wr_strb_n_oe", 32'(n_oe), 32'd1);
        chk("wr_strb_n_me", 32'(n_me), 32'd0);
        drain(20);
        data_wr = 1'b0;

        // Fetch with three wait cycles
        n_wait  = 1'b0;
        data_in = 16'h1111;
        issue(1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h1111, 3);
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("wait_addr_bus", 32'(addr_data), 32'h0100);
        fetch_req = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1 n_wait = 1'b1;
        drain(20);

        // Timeout: nWait never released
        n_wait  = 1'b0;
        data_in = 16'h2222;
        issue(1'b0, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'h1111, 15);
        @(negedge clk_sys);
        @(negedge clk_sys);
        fetch_req = 1'b0;
        drain(40);
        n_wait = 1'b1;

        // Contention from reset: DATA, FETCH, DATA, FETCH every 4 cycles
        @(posedge clk_sys);
        #1 rst = 1'b1;
        fetch_addr = 16'h2000;
        data_addr  = 16'h3000;
        data_wr    = 1'b0;
        data_in    = 16'hC0DE;
        fetch_req  = 1'b1;
        data_req   = 1'b1;
        @(posedge clk_sys);
        #1 rst = 1'b0;
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            e.is_data = (i % 2 == 0);
            e.err     = 1'b0;
            e.rd      = 16'hC0DE;
            e.cyc     = k + 3 + 4 * i;
            exp_q.push_back(e);
        end
        repeat (15) @(posedge clk_sys);
        #1;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        drain(20);

        // Reset during STRB of a read, then a normal read
        n_wait  = 1'b0;
        data_in = 16'h3333;
        @(posedge clk_sys);
        #1;
        data_req  = 1'b1;
        data_addr = 16'h4000;
        @(negedge clk_sys);
        @(negedge clk_sys);
        data_req = 1'b0;
        @(negedge clk_sys);
        chk("rststrb_in_strb", 32'(n_oe), 32'd0);
        rst = 1'b1;
        #1;
        chk("rststrb_n_me", 32'(n_me), 32'd1);
        chk("rststrb_n_oe", 32'(n_oe), 32'd1);
        chk("rststrb_ale", 32'(ale), 32'd0);
        chk("rststrb_rnw", 32'(rnw), 32'd1);
        chk("rststrb_oe", 32'(data_oe), 32'd0);
        chk("rststrb_rd_data", 32'(rd_data), 32'd0);
        chk("rststrb_addr_data", 32'(addr_data), 32'd0);
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        rst    = 1'b0;
        n_wait = 1'b1;
        repeat (4) @(posedge clk_sys);
        data_in = 16'h7777;
        issue(1'b1, 1'b0, 16'h5555, 16'h0000, 1'b0, 16'h7777, 0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("post_rst_addr_bus", 32'(addr_data), 32'h5555);
        data_req = 1'b0;
        drain(20);

        repeat (3) @(posedge clk_sys);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum STRB cycles with nWait low before the access is aborted.
REQ-002 Clock  in  1  single clock; all state changes on the rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 FetchReq in 1 instruction-fetch request (level); FetchAddr in 16 fetch address.
REQ-005 DataReq in 1 load/store request (level); DataWr in 1 (1 = write); DataAddr in 16; DataWdata in 16.
REQ-006 FetchDone out 1, DataDone out 1: one-cycle completion pulse to the owning requester.
REQ-007 BusErr out 1: one-cycle pulse coincident with the Done pulse when the access timed out.
REQ-008 RdData out 16: read data captured from the bus.
REQ-009 DataIn in 16 bus sample; AddrDataOut out 16 multiplexed address/write data; DataOe out 1 pad drive enable.
REQ-010 ALE out 1, nME out 1, nOE out 1, RnW out 1: external bus strobes. nWait in 1: active-low wait from memory.

Function
REQ-011 FSM states are IDLE, ADDR, STRB and END.
REQ-012 Transitions: IDLE->ADDR on any request; ADDR->STRB always; STRB->END when nWait=1 or the timeout is reached; END->IDLE always.
REQ-013 Arbitration happens only in IDLE:
- single request: that request wins;
- both pending: the requester not served last wins (round-robin).
REQ-014 On IDLE->ADDR the block registers the owner, address, write flag and write data. Later changes on the request inputs are ignored until IDLE.
REQ-015 ADDR: ALE=1, AddrDataOut=address, DataOe=1, nME=1, nOE=1, RnW=1.
REQ-016 STRB read: nME=0, nOE=0, RnW=1, DataOe=0.
REQ-017 STRB write: nME=0, nOE=1, RnW=0, DataOe=1, AddrDataOut=write data.
REQ-018 In a STRB cycle with nWait=1, a read captures DataIn into RdData at that edge.
REQ-019 Wait counter: cleared on ADDR->STRB; incremented in each STRB cycle with nWait=0. When the count equals MAX_WAIT with nWait still 0, the FSM goes to END with the error flag set and RdData unchanged.
REQ-020 END: nME=1, nOE=1, RnW=1, DataOe=0, ALE=0. The owner's Done pulses; BusErr pulses if the error flag is set. The END->IDLE step gives one idle bus-turnaround cycle.
REQ-021 Minimum latency is request sampled in IDLE -> Done 3 cycles later. Back-to-back accesses take 4 cycles each.
REQ-022 A request dropped mid-access does not abort the access; Done still pulses.
REQ-023 Done is never asserted for a requester that does not own the access. FetchDone and DataDone are never high together.
REQ-024 ALE and nME=0 are never asserted in the same cycle. DataOe=1 is never asserted while nOE=0.

Reset
REQ-025 While Reset=1, asynchronously:
- FSM = IDLE, last-served = fetch (data wins the first tie);
- ALE=0, nME=1, nOE=1, RnW=1, DataOe=0;
- AddrDataOut=0, RdData=0, FetchDone=0, DataDone=0, BusErr=0;
- wait counter = 0.
REQ-026 Reset mid-access abandons the access with no Done pulse. The first edge after release with a request pending enters ADDR.

Structure
REQ-027 Shared package bus_pkg holds busState_t (IDLE, ADDR, STRB, END), owner_t (FETCH, DATA) and the default for MAX_WAIT.
REQ-028 Round-robin selection is a sub-module bus_arb (inputs: two requests and last-served; outputs: grant and owner). The FSM, wait counter and output registers stay in mem_bus_ctrl.
REQ-029 All strobe outputs are registered directly from flops, with no combinational path from any input.

Verification
REQ-030 Read: DataReq=1, DataWr=0, DataAddr=16'h1234, nWait=1, memory returns 16'hBEEF -> AddrDataOut=16'h1234 with ALE=1 for 1 cycle; nME=nOE=0 for 1 cycle; DataDone pulses 3 cycles after request; RdData=16'hBEEF.
REQ-031 Write: DataWr=1, DataAddr=16'h0040, DataWdata=16'hA5A5 -> RnW=0, DataOe=1, AddrDataOut=16'hA5A5 during STRB; nOE stays 1; DataDone pulses; RdData unchanged.
REQ-032 Wait: nWait low for 3 STRB cycles on a fetch at 16'h0100 -> STRB lasts 4 cycles; FetchDone at cycle 6; BusErr=0.
REQ-033 Timeout: nWait held low, MAX_WAIT=15 -> END after 16 STRB cycles; FetchDone and BusErr pulse together; RdData unchanged.
REQ-034 Contention: FetchReq and DataReq both held high from reset -> grants alternate DATA, FETCH, DATA, FETCH, one access per 4 cycles.
REQ-035 Reset asserted during STRB of a read -> outputs return to reset values in the same cycle; no Done pulse; the next access completes normally.
